// File: rtl/wdt_pkg.sv
// Shared constants and types for the watchdog APB register block.
// Used by wdt_apb_regif and wdt_down_counter.
package wdt_pkg;

    localparam logic [11:0] OFF_LOAD    = 12'h000;
    localparam logic [11:0] OFF_VALUE   = 12'h004;
    localparam logic [11:0] OFF_CONTROL = 12'h008;
    localparam logic [11:0] OFF_INTCLR  = 12'h00C;
    localparam logic [11:0] OFF_RIS     = 12'h010;
    localparam logic [11:0] OFF_MIS     = 12'h014;
    localparam logic [11:0] OFF_LOCK    = 12'hC00;
    localparam logic [11:0] OFF_ITCR    = 12'hF00;

    localparam logic [31:0] LOCK_KEY = 32'h1ACCE551;

    localparam int CTRL_INTEN_BIT = 0;
    localparam int CTRL_RESEN_BIT = 1;
    localparam int ITCR_TEST_BIT  = 0;

    // Member order makes the packed value line up with the CONTROL bit map.
    typedef struct packed {
        logic resen;
        logic inten;
    } control_t;

endpackage

// File: rtl/wdt_down_counter.sv
// Watchdog countdown with terminal-count compare and reload.
// A load-write beats a reload, which beats expiry reload, which beats decrement.
module wdt_down_counter
    import wdt_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  LOAD_RESET = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] load,
    input  logic              load_wr,
    input  logic              reload,
    input  logic              enable,
    output logic [DATA_W-1:0] count,
    output logic              value_eq0
);

    logic is_zero;

    assign is_zero   = (count == '0);
    assign value_eq0 = enable & is_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= LOAD_RESET;
        end else if (load_wr || reload) begin
            count <= load;
        end else if (enable && is_zero) begin
            count <= load;
        end else if (enable) begin
            count <= count - DATA_W'(1);
        end
    end

endmodule

// File: rtl/wdt_apb_regif.sv
// APB3 register interface and countdown for the watchdog timer.
// Define WDT_LOCK_EN to build the LOCK register at 0xC00.
module wdt_apb_regif
    import wdt_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 12,
    parameter logic [DATA_W-1:0]  LOAD_RESET = 32'hFFFF_FFFF
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              wdt_interrupt,
    output logic              value_eq0,
    output logic              wr_en_icr,
    output logic              int_en,
    output logic              resen,
    output logic              test
);

    logic              access;
    logic              wr;
    logic              wr_ok;
    logic              sel_load, sel_value, sel_control, sel_intclr;
    logic              sel_ris, sel_mis, sel_lock, sel_itcr;
    logic              mapped;
    logic              locked;
    logic              wr_load, wr_control, wr_intclr, wr_itcr;
    logic              inten_rise;
    logic [DATA_W-1:0] load_reg;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] cnt_load;
    control_t          ctrl;
    logic              test_reg;
    logic              icr_pulse;

    assign access = psel & penable;
    assign wr     = access & pwrite;

    assign sel_load    = (paddr == ADDR_W'(OFF_LOAD));
    assign sel_value   = (paddr == ADDR_W'(OFF_VALUE));
    assign sel_control = (paddr == ADDR_W'(OFF_CONTROL));
    assign sel_intclr  = (paddr == ADDR_W'(OFF_INTCLR));
    assign sel_ris     = (paddr == ADDR_W'(OFF_RIS));
    assign sel_mis     = (paddr == ADDR_W'(OFF_MIS));
    assign sel_lock    = (paddr == ADDR_W'(OFF_LOCK));
    assign sel_itcr    = (paddr == ADDR_W'(OFF_ITCR));

    // LOCK stays a mapped offset even when the lock itself is not built.
    assign mapped = sel_load | sel_value | sel_control | sel_intclr |
                    sel_ris  | sel_mis   | sel_lock    | sel_itcr;

`ifdef WDT_LOCK_EN
    always_ff @(posedge pclk) begin
        if (preset) begin
            locked <= 1'b0;
        end else if (wr && sel_lock) begin
            locked <= (pwdata != DATA_W'(LOCK_KEY));
        end
    end
`else
    assign locked = 1'b0;
`endif

    assign wr_ok      = wr & ~locked;
    assign wr_load    = wr_ok & sel_load;
    assign wr_control = wr_ok & sel_control;
    assign wr_intclr  = wr_ok & sel_intclr;
    assign wr_itcr    = wr_ok & sel_itcr;

    assign inten_rise = wr_control & pwdata[CTRL_INTEN_BIT] & ~ctrl.inten;

    always_ff @(posedge pclk) begin
        if (preset) begin
            load_reg  <= LOAD_RESET;
            ctrl      <= '0;
            test_reg  <= 1'b0;
            icr_pulse <= 1'b0;
        end else begin
            if (wr_load) begin
                load_reg <= pwdata;
            end
            if (wr_control) begin
                ctrl.inten <= pwdata[CTRL_INTEN_BIT];
                ctrl.resen <= pwdata[CTRL_RESEN_BIT];
            end
            if (wr_itcr) begin
                test_reg <= pwdata[ITCR_TEST_BIT];
            end
            icr_pulse <= wr_intclr;
        end
    end

    // A LOAD write takes the bus value directly; every other reload uses LOAD.
    assign cnt_load = wr_load ? pwdata : load_reg;

    wdt_down_counter #(
        .DATA_W     (DATA_W),
        .LOAD_RESET (LOAD_RESET)
    ) u_counter (
        .clk       (pclk),
        .rst       (preset),
        .load      (cnt_load),
        .load_wr   (wr_load),
        .reload    (wr_intclr | inten_rise),
        .enable    (ctrl.inten),
        .count     (count),
        .value_eq0 (value_eq0)
    );

    always_comb begin
        prdata = '0;
        if (access) begin
            if (sel_load) begin
                prdata = load_reg;
            end else if (sel_value) begin
                prdata = count;
            end else if (sel_control) begin
                prdata = {{(DATA_W-2){1'b0}}, ctrl};
            end else if (sel_ris) begin
                prdata = {{(DATA_W-1){1'b0}}, wdt_interrupt};
            end else if (sel_mis) begin
                prdata = {{(DATA_W-1){1'b0}}, wdt_interrupt & ctrl.inten};
            end else if (sel_lock) begin
                prdata = {{(DATA_W-1){1'b0}}, locked};
            end else if (sel_itcr) begin
                prdata = {{(DATA_W-1){1'b0}}, test_reg};
            end
        end
    end

    assign pready    = 1'b1;
    assign pslverr   = access & ~mapped;
    assign wr_en_icr = icr_pulse;
    assign int_en    = ctrl.inten;
    assign resen     = ctrl.resen;
    assign test      = test_reg;

endmodule

// File: tb/tb_wdt_apb_regif.sv
// Self-checking bench for wdt_apb_regif with a behavioural register/counter model.
// Honours WDT_LOCK_EN the same way the design does.
module tb_wdt_apb_regif;

`ifdef WDT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam logic [31:0] KEY = 32'h1ACCE551;

    logic        pclk = 1'b0;
    logic        preset, psel, penable, pwrite, wdt_interrupt;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr, value_eq0, wr_en_icr, int_en, resen, test;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] m_load, m_cnt;
    logic        m_inten, m_resen, m_test, m_locked, m_icr;

    logic [11:0] addrs [10] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                12'h014, 12'hC00, 12'hF00, 12'h020, 12'h001};

    always #5 pclk = ~pclk;

    wdt_apb_regif dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .wdt_interrupt(wdt_interrupt),
        .value_eq0(value_eq0), .wr_en_icr(wr_en_icr), .int_en(int_en),
        .resen(resen), .test(test)
    );

    function automatic bit m_mapped(input logic [11:0] a);
        return a inside {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'hC00, 12'hF00};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h000: return m_load;
            12'h004: return m_cnt;
            12'h008: return {30'd0, m_resen, m_inten};
            12'h010: return {31'd0, wdt_interrupt};
            12'h014: return {31'd0, wdt_interrupt & m_inten};
            12'hC00: return LOCK_EN ? {31'd0, m_locked} : 32'd0;
            12'hF00: return {31'd0, m_test};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        bit          w, rw;
        logic [31:0] old_load, old_cnt;
        logic        old_inten;
        if (preset) begin
            m_load = 32'hFFFF_FFFF; m_cnt = 32'hFFFF_FFFF;
            m_inten = 0; m_resen = 0; m_test = 0; m_locked = 0; m_icr = 0;
        end else begin
            rw = psel && penable && pwrite;
            w  = rw && !(LOCK_EN && m_locked);
            old_load = m_load; old_cnt = m_cnt; old_inten = m_inten;
            m_icr = w && paddr == 12'h00C;
            if (w && paddr == 12'h000)                                 m_cnt = pwdata;
            else if (w && paddr == 12'h00C)                            m_cnt = old_load;
            else if (w && paddr == 12'h008 && pwdata[0] && !old_inten) m_cnt = old_load;
            else if (old_inten && old_cnt == 0)                        m_cnt = old_load;
            else if (old_inten)                                        m_cnt = old_cnt - 1;
            if (w && paddr == 12'h000) m_load = pwdata;
            if (w && paddr == 12'h008) begin m_inten = pwdata[0]; m_resen = pwdata[1]; end
            if (w && paddr == 12'hF00) m_test = pwdata[0];
            if (LOCK_EN && rw && paddr == 12'hC00) m_locked = (pwdata != KEY);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        model_update();
        @(negedge pclk);
    endtask

    task automatic bus_idle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        step();
        penable = 1;
        #1 err = pslverr;
        step();
        bus_idle();
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        step();
        penable = 1;
        #1 begin d = prdata; err = pslverr; end
        step();
        bus_idle();
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        preset = 1; step(); step(); preset = 0;
        #1;
        checks++;
        if ({wr_en_icr, int_en, resen, test, value_eq0, pslverr} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs got=%b want=000000", {wr_en_icr, int_en, resen, test, value_eq0, pslverr});
        end
        checks++;
        if (prdata !== 32'd0) begin errors++; $display("FAIL reset_prdata_idle got=%h want=0", prdata); end
        apb_read(12'h000, d, e);
        checks++;
        if (d !== 32'hFFFF_FFFF || e !== 1'b0) begin errors++; $display("FAIL reset_load got=%h err=%b want=ffffffff err=0", d, e); end
        apb_read(12'h004, d, e);
        checks++;
        if (d !== 32'hFFFF_FFFF || e !== 1'b0) begin errors++; $display("FAIL reset_value got=%h err=%b want=ffffffff err=0", d, e); end
        apb_read(12'h008, d, e);
        checks++;
        if (d !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL reset_control got=%h err=%b want=0 err=0", d, e); end
    endtask

    task automatic test_countdown();
        logic e;
        logic [31:0] exp_seq [8] = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd5, 32'd4};
        apb_write(12'h000, 32'd5, e);
        apb_write(12'h008, 32'd1, e);
        psel = 1; penable = 1; pwrite = 0; paddr = 12'h004;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (prdata !== exp_seq[i]) begin errors++; $display("FAIL countdown_value[%0d] got=%0d want=%0d", i, prdata, exp_seq[i]); end
            checks++;
            if (value_eq0 !== (i == 5)) begin errors++; $display("FAIL countdown_eq0[%0d] got=%b want=%b", i, value_eq0, i == 5); end
            step();
        end
        paddr = 12'h014;
        for (int i = 0; i < 2; i++) begin
            wdt_interrupt = (i == 0);
            #1;
            checks++;
            if (prdata !== {31'd0, wdt_interrupt}) begin errors++; $display("FAIL mis_track got=%h want=%h", prdata, {31'd0, wdt_interrupt}); end
            step();
        end
        bus_idle();
    endtask

    task automatic test_intclr();
        logic e; int n = 0;
        while (m_cnt != 32'd4 && n < 50) begin step(); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL intclr_wait got=timeout want=value_4"); end
        apb_write(12'h00C, 32'hDEAD, e);
        psel = 1; penable = 1; pwrite = 0; paddr = 12'h004;
        #1;
        checks++;
        if (wr_en_icr !== 1'b1) begin errors++; $display("FAIL intclr_pulse got=%b want=1", wr_en_icr); end
        checks++;
        if (prdata !== 32'd5) begin errors++; $display("FAIL intclr_reload got=%0d want=5", prdata); end
        step();
        #1;
        checks++;
        if (wr_en_icr !== 1'b0) begin errors++; $display("FAIL intclr_pulse_end got=%b want=0", wr_en_icr); end
        checks++;
        if (prdata !== 32'd4) begin errors++; $display("FAIL intclr_after got=%0d want=4", prdata); end
        bus_idle();
        step();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        psel = 1; penable = 1; pwrite = 1; paddr = 12'h00C; pwdata = $urandom;
        step();
        #1 if (wr_en_icr === 1'b1) pulses++;
        pwdata = $urandom;
        step();
        #1 if (wr_en_icr === 1'b1) pulses++;
        bus_idle();
        step();
        #1;
        checks++;
        if (pulses != 2 || wr_en_icr !== 1'b0) begin
            errors++; $display("FAIL b2b_intclr got=%0d pulses tail=%b want=2 pulses tail=0", pulses, wr_en_icr);
        end
    endtask

    task automatic test_lock();
        logic [31:0] d; logic e;
        apb_write(12'hC00, 32'h0, e);
        apb_write(12'h000, 32'd7, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL lock_load_err got=%b want=0", e); end
        apb_read(12'hC00, d, e);
        checks++;
        if (d !== (LOCK_EN ? 32'd1 : 32'd0)) begin errors++; $display("FAIL lock_read got=%h want=%h", d, LOCK_EN ? 32'd1 : 32'd0); end
        apb_read(12'h000, d, e);
        checks++;
        if (d !== (LOCK_EN ? 32'd5 : 32'd7)) begin errors++; $display("FAIL lock_load got=%0d want=%0d", d, LOCK_EN ? 5 : 7); end
        apb_write(12'h00C, 32'h1, e);
        #1;
        checks++;
        if (wr_en_icr !== !LOCK_EN) begin errors++; $display("FAIL lock_intclr got=%b want=%b", wr_en_icr, !LOCK_EN); end
        apb_write(12'hC00, KEY, e);
        apb_read(12'hC00, d, e);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL unlock_read got=%h want=0", d); end
        apb_write(12'h000, 32'd7, e);
        apb_read(12'h000, d, e);
        checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL unlock_load got=%0d want=7", d); end
    endtask

    task automatic test_error_reset();
        logic [31:0] d; logic e; int n = 0;
        apb_read(12'h020, d, e);
        checks++;
        if (d !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL unmapped_read got=%h err=%b want=0 err=1", d, e); end
        apb_write(12'h004, 32'h1234, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL ro_write_err got=%b want=0", e); end
        apb_write(12'h000, 32'd10, e);
        apb_write(12'h008, 32'd3, e);
        while (m_cnt != 32'd3 && n < 50) begin step(); n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL midop_wait got=timeout want=value_3"); end
        preset = 1;
        step();
        preset = 0;
        psel = 1; penable = 1; pwrite = 0; paddr = 12'h004;
        #1;
        checks++;
        if (prdata !== 32'hFFFF_FFFF || int_en !== 1'b0 || value_eq0 !== 1'b0 || resen !== 1'b0) begin
            errors++; $display("FAIL midop_reset got=%h inten=%b eq0=%b resen=%b want=ffffffff 0 0 0", prdata, int_en, value_eq0, resen);
        end
        paddr = 12'h00C; pwrite = 1;
        step();
        bus_idle(); preset = 1;
        step();
        preset = 0;
        #1;
        checks++;
        if (wr_en_icr !== 1'b0) begin errors++; $display("FAIL reset_cancels_pulse got=%b want=0", wr_en_icr); end
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 600; i++) begin
            preset  = ($urandom_range(0, 63) == 0);
            psel    = ($urandom_range(0, 3) != 0);
            penable = $urandom_range(0, 1);
            pwrite  = $urandom_range(0, 1);
            k       = $urandom_range(0, 9);
            paddr   = addrs[k];
            if (paddr == 12'h000) pwdata = $urandom_range(0, 6);
            else if (paddr == 12'hC00) pwdata = $urandom_range(0, 1) ? KEY : $urandom;
            else pwdata = $urandom;
            wdt_interrupt = $urandom_range(0, 1);
            #1;
            checks++;
            if (prdata !== ((psel && penable) ? m_read(paddr) : 32'd0)) begin
                errors++; $display("FAIL rand_prdata[%0d] addr=%h got=%h want=%h", i, paddr, prdata, (psel && penable) ? m_read(paddr) : 32'd0);
            end
            checks++;
            if (pslverr !== (psel && penable && !m_mapped(paddr))) begin
                errors++; $display("FAIL rand_pslverr[%0d] got=%b want=%b", i, pslverr, psel && penable && !m_mapped(paddr));
            end
            checks++;
            if ({value_eq0, wr_en_icr, int_en, resen, test} !== {m_inten && m_cnt == 0, m_icr, m_inten, m_resen, m_test}) begin
                errors++; $display("FAIL rand_flags[%0d] got=%b want=%b", i, {value_eq0, wr_en_icr, int_en, resen, test},
                                   {m_inten && m_cnt == 0, m_icr, m_inten, m_resen, m_test});
            end
            step();
        end
        preset = 0;
        bus_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; wdt_interrupt = 0;
        m_load = '1; m_cnt = '1; m_inten = 0; m_resen = 0; m_test = 0; m_locked = 0; m_icr = 0;
        @(negedge pclk);
        test_reset();
        test_countdown();
        test_intclr();
        test_back_to_back();
        test_lock();
        test_error_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
